// File: rtl/mux_nto1_pipe.sv
// N-to-1 valid/ready multiplexer with a single registered output stage.
// Channel choice is either an explicit select (MODE=0) or round-robin over valid inputs (MODE=1).

module mux_nto1_lane #(
    parameter int SEL_W = 2,
    parameter int K     = 0
) (
    input  logic             out_free,
    input  logic             has_cand,
    input  logic [SEL_W-1:0] cand,
    output logic             ready
);
    assign ready = out_free && has_cand && (cand == SEL_W'(K));
endmodule

module mux_nto1_pipe #(
    parameter int size  = 32,
    parameter int N     = 4,
    parameter int SEL_W = 2,
    parameter int MODE  = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [N*size-1:0] data_i,
    input  logic [N-1:0]      valid_i,
    output logic [N-1:0]      ready_o,
    input  logic [SEL_W-1:0]  select_i,
    output logic [size-1:0]   data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [SEL_W-1:0]  grant_o
);
    logic             out_free;
    logic             has_cand;
    logic [SEL_W-1:0] cand;
    logic [SEL_W-1:0] rr_ptr;
    logic [size-1:0]  sel_data;
    logic             xfer;

    // Gating with rst_i keeps every ready low while reset is held.
    assign out_free = rst_i && (!valid_o || ready_i);

    always_comb begin
        cand     = '0;
        has_cand = 1'b0;
        if (MODE == 0) begin
            cand     = select_i;
            has_cand = (32'(select_i) < N);
        end else begin
            // Walk downward so the last hit is the first valid channel at/after rr_ptr.
            for (int i = N - 1; i >= 0; i--) begin
                int idx;
                idx = int'(rr_ptr) + i;
                if (idx >= N) idx = idx - N;
                if (valid_i[idx]) begin
                    cand     = SEL_W'(idx);
                    has_cand = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < N; k++) begin
            if (cand == SEL_W'(k)) sel_data = data_i[k*size +: size];
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_lane
        mux_nto1_lane #(.SEL_W(SEL_W), .K(k)) u_lane (
            .out_free (out_free),
            .has_cand (has_cand),
            .cand     (cand),
            .ready    (ready_o[k])
        );
    end

    assign xfer = |(ready_o & valid_i);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            data_o  <= '0;
            valid_o <= 1'b0;
            grant_o <= '0;
            rr_ptr  <= '0;
        end else begin
            if (out_free) begin
                if (xfer) begin
                    data_o  <= sel_data;
                    grant_o <= cand;
                    valid_o <= 1'b1;
                end else begin
                    valid_o <= 1'b0;
                end
            end
            if (MODE == 1 && xfer)
                rr_ptr <= (32'(cand) == N - 1) ? '0 : cand + 1'b1;
        end
    end
endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Directed bench for mux_nto1_pipe: explicit select (N=4 and N=3) and round-robin (N=4).
`timescale 1ns/1ps
module tb_mux_nto1_pipe;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // A: MODE=0, N=4
    logic [127:0] a_data;
    logic [3:0]   a_valid, a_ready;
    logic [1:0]   a_sel, a_grant;
    logic [31:0]  a_dout;
    logic         a_vout, a_rdy;
    // B: MODE=0, N=3
    logic [95:0]  b_data;
    logic [2:0]   b_valid, b_ready;
    logic [1:0]   b_sel, b_grant;
    logic [31:0]  b_dout;
    logic         b_vout, b_rdy;
    // C: MODE=1, N=4
    logic [127:0] c_data;
    logic [3:0]   c_valid, c_ready;
    logic [1:0]   c_sel, c_grant;
    logic [31:0]  c_dout;
    logic         c_vout, c_rdy;

    mux_nto1_pipe #(.size(32), .N(4), .SEL_W(2), .MODE(0)) u_a (
        .clk_i(clk), .rst_i(rst), .data_i(a_data), .valid_i(a_valid), .ready_o(a_ready),
        .select_i(a_sel), .data_o(a_dout), .valid_o(a_vout), .ready_i(a_rdy), .grant_o(a_grant));
    mux_nto1_pipe #(.size(32), .N(3), .SEL_W(2), .MODE(0)) u_b (
        .clk_i(clk), .rst_i(rst), .data_i(b_data), .valid_i(b_valid), .ready_o(b_ready),
        .select_i(b_sel), .data_o(b_dout), .valid_o(b_vout), .ready_i(b_rdy), .grant_o(b_grant));
    mux_nto1_pipe #(.size(32), .N(4), .SEL_W(2), .MODE(1)) u_c (
        .clk_i(clk), .rst_i(rst), .data_i(c_data), .valid_i(c_valid), .ready_o(c_ready),
        .select_i(c_sel), .data_o(c_dout), .valid_o(c_vout), .ready_i(c_rdy), .grant_o(c_grant));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle so registered outputs can be sampled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_data = '0; a_valid = '0; a_sel = '0; a_rdy = 1'b0;
        b_data = '0; b_valid = '0; b_sel = '0; b_rdy = 1'b0;
        c_data = '0; c_valid = '0; c_sel = '0; c_rdy = 1'b0;

        // Reset held: outputs zero and no ready even with valid inputs.
        a_valid = 4'b1111; a_rdy = 1'b1;
        #12;
        chk("rst_vout", a_vout, 0);
        chk("rst_dout", a_dout, 0);
        chk("rst_grant", a_grant, 0);
        chk("rst_ready", a_ready, 0);
        a_valid = '0;
        rst = 1'b1;
        tick();
        chk("post_rst_vout", a_vout, 0);

        // MODE=0 streaming on channel 2.
        a_sel = 2'd2; a_valid = 4'b0100; a_rdy = 1'b1;
        a_data[95:64] = 32'hA0;
        #1 chk("s0_ready", a_ready, 4'b0100);
        tick();
        chk("s0_vout", a_vout, 1);
        chk("s0_dout", a_dout, 32'hA0);
        chk("s0_grant", a_grant, 2);
        a_data[95:64] = 32'hA1;
        #1 chk("s1_ready", a_ready, 4'b0100);
        tick();
        chk("s1_dout", a_dout, 32'hA1);
        chk("s1_vout", a_vout, 1);

        // Backpressure for three cycles with 0xA2 waiting.
        a_data[95:64] = 32'hA2; a_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp_ready", a_ready, 0);
            tick();
            chk("bp_dout", a_dout, 32'hA1);
            chk("bp_vout", a_vout, 1);
        end
        a_rdy = 1'b1;
        #1 chk("bp_rel_ready", a_ready, 4'b0100);
        tick();
        chk("bp_rel_dout", a_dout, 32'hA2);
        chk("bp_rel_grant", a_grant, 2);
        a_valid = '0;
        tick();
        chk("drain_vout", a_vout, 0);
        chk("drain_dout_hold", a_dout, 32'hA2);

        // Asynchronous reset mid-stall.
        a_valid = 4'b0100; a_data[95:64] = 32'hB5;
        tick();
        chk("ar_load_vout", a_vout, 1);
        a_valid = '0; a_rdy = 1'b0;
        #3 rst = 1'b0;
        #1;
        chk("ar_vout", a_vout, 0);
        chk("ar_dout", a_dout, 0);
        chk("ar_grant", a_grant, 0);
        chk("ar_ready", a_ready, 0);
        #2 rst = 1'b1;
        tick();
        chk("ar_after_vout", a_vout, 0);
        tick();
        chk("ar_after2_vout", a_vout, 0);

        // Invalid select, N=3.
        b_valid = 3'b111; b_sel = 2'd1; b_rdy = 1'b1;
        b_data = {32'h22, 32'h11, 32'h00};
        #1 chk("inv_ready_ok", b_ready, 3'b010);
        tick();
        chk("inv_load_dout", b_dout, 32'h11);
        chk("inv_load_grant", b_grant, 1);
        b_sel = 2'd3; b_rdy = 1'b0;
        #1 chk("inv_ready_stall", b_ready, 0);
        tick();
        chk("inv_stall_vout", b_vout, 1);
        b_rdy = 1'b1;
        #1 chk("inv_ready_none", b_ready, 0);
        tick();
        chk("inv_vout_fall", b_vout, 0);
        chk("inv_dout_hold", b_dout, 32'h11);

        // Round-robin fairness: all channels valid.
        c_data = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
        c_valid = 4'b1111; c_rdy = 1'b1;
        #1 chk("rr_ready0", c_ready, 4'b0001);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("rr_grant", c_grant, i % 4);
            chk("rr_dout", c_dout, 32'hC0 + (i % 4));
        end
        // One more transfer leaves rr_ptr at 1.
        tick();
        chk("rr_pre_grant", c_grant, 0);

        // Skip and wrap with channels 0 and 3 valid.
        c_valid = 4'b1001;
        #1 chk("sw_ready", c_ready, 4'b1000);
        tick();
        chk("sw_g0", c_grant, 3);
        tick();
        chk("sw_g1", c_grant, 0);
        tick();
        chk("sw_g2", c_grant, 3);
        tick();
        chk("sw_g3", c_grant, 0);
        c_valid = '0;
        tick();
        chk("sw_idle_vout", c_vout, 0);
        tick();
        chk("sw_idle2_vout", c_vout, 0);
        c_valid = 4'b1111;
        #1 chk("sw_ptr_hold_ready", c_ready, 4'b0010);
        tick();
        chk("sw_ptr_hold_grant", c_grant, 1);
        chk("sw_ptr_hold_dout", c_dout, 32'hC1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
